multibyte_add_seq: RTL and testbench

MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

---
 rtl/multibyte_add_seq.sv | 112 +++++++++++
 tb/tb_multibyte_add_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multibyte_add_seq.sv
// Byte-serial adder: one shared 8-bit add per cycle, result valid NBYTES cycles after accept.
// Single operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module multibyte_add_seq #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  cout,
   output logic                  ovf,
   output logic                  busy
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [NBYTES-1:0][7:0] a_q;
   logic [NBYTES-1:0][7:0] b_q;
   logic [NBYTES-1:0][7:0] sum_q;
   logic                   carry;
   logic [IW-1:0]          idx;

   logic [7:0]             byte_a;
   logic [7:0]             byte_b;
   logic [7:0]             byte_s;
   logic                   byte_c;
   logic                   c_into_msb;
   logic                   accept;
   logic                   last;

   // Shared byte adder; carry into bit 7 recovered from the sum bit for overflow.
   always_comb begin
      byte_a              = a_q[idx];
      byte_b              = b_q[idx];
      {byte_c, byte_s}    = {1'b0, byte_a} + {1'b0, byte_b} + {8'd0, carry};
      c_into_msb          = byte_a[7] ^ byte_b[7] ^ byte_s[7];
      last                = (idx == LAST);
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      accept = in_ready & in_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         sum_q <= '0;
         carry <= 1'b0;
         idx   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         carry <= cin;
         idx   <= '0;
      end else if (state == RUN) begin
         sum_q[idx] <= byte_s;
         carry      <= byte_c;
         if (last) begin
            cout <= byte_c;
            ovf  <= c_into_msb ^ byte_c;
            idx  <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign sum = sum_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq (NBYTES=4): table vectors, random vectors, backpressure,
// ignored-input and mid-operation reset sequences, checked through an expected-result queue.
module tb_multibyte_add_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[8];

   multibyte_add_seq #(.NBYTES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
      exp_t e;
      logic [32:0] full;
      full   = {1'b0, x} + {1'b0, y} + {32'd0, c};
      e.sum  = full[31:0];
      e.cout = full[32];
      e.ovf  = (x[31] == y[31]) && (e.sum[31] != x[31]);
      return e;
   endfunction

   // Drive one operation, then check latency, hold behaviour and handoff.
   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic c,
                        input exp_t e, input int hold, input bit scramble, input bit early_rdy);
      int   cycles;
      exp_t got;
      exp_t want;
      @(negedge clk);
      chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
      in_valid  = 1'b1;
      a         = x;
      b         = y;
      cin       = c;
      out_ready = early_rdy;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      chk("busy_after_accept", {63'd0, busy}, 64'd1);
      cycles = 0;
      while (!out_valid && cycles < 20) begin
         if (scramble) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
            b        = $urandom;
            cin      = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         cycles++;
      end
      in_valid = 1'b0;
      chk("latency", 64'(cycles), 64'd4);
      got.sum  = sum;
      got.cout = cout;
      got.ovf  = ovf;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
         chk("hold_result", {31'd0, sum, cout, ovf}, {31'd0, got.sum, got.cout, got.ovf});
      end
      if (sb.size() == 0) begin
         chk("scoreboard_nonempty", 64'd0, 64'd1);
      end else begin
         want = sb.pop_front();
         chk("sum", {32'd0, sum}, {32'd0, want.sum});
         chk("cout", {63'd0, cout}, {63'd0, want.cout});
         chk("ovf", {63'd0, ovf}, {63'd0, want.ovf});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("in_ready_after_handoff", {63'd0, in_ready}, 64'd1);
      chk("out_valid_after_handoff", {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      exp_t e;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      int          seen;

      tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
      tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
      tbl[6] = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 1'b0, 1'b0};
      tbl[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};

      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_result", {31'd0, sum, cout, ovf}, 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b0;

      for (int i = 0; i < 8; i++) begin
         e.sum  = tbl[i].sum;
         e.cout = tbl[i].cout;
         e.ovf  = tbl[i].ovf;
         do_op(tbl[i].a, tbl[i].b, tbl[i].cin, e, 0, 1'b0, (i == 2));
      end

      // Backpressure: result held for 5 cycles.
      e = model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, e, 5, 1'b0, 1'b0);

      // Inputs wiggled during RUN must not disturb the latched operands.
      e = model(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b1);
      do_op(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b1, e, 1, 1'b1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         e  = model(ra, rb, rc);
         do_op(ra, rb, rc, e, i % 3, 1'(i % 2), 1'b0);
      end

      // Reset on the second RUN cycle aborts the add.
      @(negedge clk);
      in_valid = 1'b1;
      a        = 32'hDEAD_BEEF;
      b        = 32'h0101_0101;
      cin      = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("abort_busy_run1", {63'd0, busy}, 64'd1);
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_sum", {32'd0, sum}, 64'd0);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_out_valid", 64'(seen), 64'd0);
      e = model(32'h1234_5678, 32'h1111_1111, 1'b0);
      do_op(32'h1234_5678, 32'h1111_1111, 1'b0, e, 0, 1'b0, 1'b0);

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
